// File: rtl/control_sequencer_if.sv
// Program-memory fetch handshake between the instruction memory and the sequencer.
interface control_sequencer_if #(
   parameter int WORD_W = 16
);
   logic [WORD_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (output mem_rdata, output mem_ready);
   modport slave  (input  mem_rdata, input  mem_ready);
endinterface

// File: rtl/control_sequencer.sv
// Upstream control stage: fetch/exec1/exec2 FSM, instruction register,
// condition flags fed from the accumulator, and a retired-instruction counter.
module control_sequencer #(
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   control_sequencer_if.slave mem_if,
   input  logic              run_i,
   input  logic [WORD_W-1:0] acc_i,
   input  logic              acc_load_i,
   output logic [2:0]        state_o,
   output logic [3:0]        inst_o,
   output logic [11:0]       operand_o,
   output logic              eq_bar_o,
   output logic              mi_o,
   output logic              skip_o,
   output logic              halted_o,
   output logic [15:0]       retired_o
);

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STP = 4'b0111;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC1 = 3'd2,
      S_EXEC2 = 3'd3,
      S_HALT  = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [WORD_W-1:0] ir_q, ir_d;
   logic [15:0]       retired_q, retired_d;
   logic              eq_bar_q, mi_q, flag_pending_q;
   logic              fetch_done, retire;
   logic [3:0]        opcode;

   assign opcode     = ir_q[WORD_W-1 -: 4];
   assign fetch_done = (state_q == S_FETCH) && mem_if.mem_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; run only matters in IDLE and HALT, so an instruction always completes
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE:  if (run_i) state_d = S_FETCH;
         S_FETCH: if (mem_if.mem_ready) state_d = S_EXEC1;
         S_EXEC1: begin
            retire = 1'b1;
            if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
               state_d = S_EXEC2;
               retire  = 1'b0;
            end else if (opcode == OP_STP) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_EXEC2: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_HALT:  if (!run_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Decoder-facing outputs decoded from the current state
   always_comb begin
      state_o  = 3'b000;
      halted_o = 1'b0;
      case (state_q)
         S_FETCH: state_o  = 3'b001;
         S_EXEC1: state_o  = 3'b010;
         S_EXEC2: state_o  = 3'b100;
         S_HALT:  halted_o = 1'b1;
         default: state_o  = 3'b000;
      endcase
      skip_o = fetch_done;
   end

   assign ir_d      = fetch_done ? mem_if.mem_rdata : ir_q;
   assign retired_d = retired_q + 16'd1;

   // Instruction register: loads only on a completed fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ir_q <= '0;
      else        ir_q <= ir_d;
   end

   // Retired counter: written only on completion so it wraps naturally at 0xFFFF
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      retired_q <= '0;
      else if (retire) retired_q <= retired_d;
   end

   // Flags trail an accumulator load by one edge, when the new acc value is stable;
   // a load coinciding with a capture re-arms the pending bit for the newer value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_pending_q <= 1'b0;
         eq_bar_q       <= 1'b0;
         mi_q           <= 1'b0;
      end else begin
         flag_pending_q <= acc_load_i;
         if (flag_pending_q) begin
            eq_bar_q <= |acc_i;
            mi_q     <= acc_i[WORD_W-1];
         end
      end
   end

   assign inst_o    = opcode;
   assign operand_o = ir_q[11:0];
   assign eq_bar_o  = eq_bar_q;
   assign mi_o      = mi_q;
   assign retired_o = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer plus hand sequences for
// reset-abort and retired-counter wrap.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [15:0] acc;
   logic        acc_load;
   logic [2:0]  state;
   logic [3:0]  inst;
   logic [11:0] operand;
   logic        eq_bar, mi, skip, halted;
   logic [15:0] retired;

   int n_tests = 0;
   int n_fail  = 0;

   control_sequencer_if #(.WORD_W(16)) mem_if ();

   control_sequencer #(.WORD_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_if    (mem_if),
      .run_i     (run),
      .acc_i     (acc),
      .acc_load_i(acc_load),
      .state_o   (state),
      .inst_o    (inst),
      .operand_o (operand),
      .eq_bar_o  (eq_bar),
      .mi_o      (mi),
      .skip_o    (skip),
      .halted_o  (halted),
      .retired_o (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        run;
      logic        rdy;
      logic [15:0] rdata;
      logic [15:0] acc;
      logic        ld;
      logic [2:0]  st;
      logic        skip;
      logic [3:0]  inst;
      logic [11:0] op;
      logic        eq;
      logic        mi;
      logic        halt;
      logic [15:0] ret;
   } vec_t;

   vec_t tbl[24];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st, input logic sk,
                          input logic [3:0] in, input logic [11:0] op, input logic eq,
                          input logic m, input logic hl, input logic [15:0] rt);
      chk({tag, ".state"},   32'(state),   32'(st));
      chk({tag, ".skip"},    32'(skip),    32'(sk));
      chk({tag, ".inst"},    32'(inst),    32'(in));
      chk({tag, ".operand"}, 32'(operand), 32'(op));
      chk({tag, ".eq_bar"},  32'(eq_bar),  32'(eq));
      chk({tag, ".mi"},      32'(mi),      32'(m));
      chk({tag, ".halted"},  32'(halted),  32'(hl));
      chk({tag, ".retired"}, 32'(retired), 32'(rt));
   endtask

   initial begin
      //          run rdy rdata     acc       ld  st      sk inst  op       eq mi hl ret
      tbl[0]  = '{0, 0, 16'h0000, 16'h0000, 0, 3'b000, 0, 4'h0, 12'h000, 0, 0, 0, 16'd0};
      tbl[1]  = '{1, 0, 16'h0000, 16'h0000, 0, 3'b000, 0, 4'h0, 12'h000, 0, 0, 0, 16'd0};
      tbl[2]  = '{1, 1, 16'h0005, 16'h0000, 0, 3'b001, 1, 4'h0, 12'h000, 0, 0, 0, 16'd0};
      tbl[3]  = '{1, 1, 16'h0005, 16'h0000, 0, 3'b010, 0, 4'h0, 12'h005, 0, 0, 0, 16'd0};
      tbl[4]  = '{1, 0, 16'h0000, 16'h8000, 1, 3'b100, 0, 4'h0, 12'h005, 0, 0, 0, 16'd0};
      tbl[5]  = '{1, 0, 16'h0000, 16'h8000, 0, 3'b001, 0, 4'h0, 12'h005, 0, 0, 0, 16'd1};
      tbl[6]  = '{1, 0, 16'h0000, 16'h8000, 0, 3'b001, 0, 4'h0, 12'h005, 1, 1, 0, 16'd1};
      tbl[7]  = '{1, 0, 16'h0000, 16'h8000, 0, 3'b001, 0, 4'h0, 12'h005, 1, 1, 0, 16'd1};
      tbl[8]  = '{1, 1, 16'h2123, 16'h8000, 0, 3'b001, 1, 4'h0, 12'h005, 1, 1, 0, 16'd1};
      tbl[9]  = '{1, 0, 16'h0000, 16'h8000, 0, 3'b010, 0, 4'h2, 12'h123, 1, 1, 0, 16'd1};
      tbl[10] = '{1, 0, 16'h0000, 16'h0000, 1, 3'b100, 0, 4'h2, 12'h123, 1, 1, 0, 16'd1};
      tbl[11] = '{1, 1, 16'h4010, 16'h0000, 0, 3'b001, 1, 4'h2, 12'h123, 1, 1, 0, 16'd2};
      tbl[12] = '{1, 0, 16'h0000, 16'h0000, 0, 3'b010, 0, 4'h4, 12'h010, 0, 0, 0, 16'd2};
      tbl[13] = '{1, 1, 16'h7000, 16'h0000, 0, 3'b001, 1, 4'h4, 12'h010, 0, 0, 0, 16'd3};
      tbl[14] = '{1, 0, 16'h0000, 16'h0000, 0, 3'b010, 0, 4'h7, 12'h000, 0, 0, 0, 16'd3};
      tbl[15] = '{1, 0, 16'h0000, 16'h0000, 0, 3'b000, 0, 4'h7, 12'h000, 0, 0, 1, 16'd4};
      tbl[16] = '{1, 1, 16'h0000, 16'h0000, 0, 3'b000, 0, 4'h7, 12'h000, 0, 0, 1, 16'd4};
      tbl[17] = '{0, 0, 16'h0000, 16'h0000, 0, 3'b000, 0, 4'h7, 12'h000, 0, 0, 1, 16'd4};
      tbl[18] = '{0, 0, 16'h0000, 16'h0000, 0, 3'b000, 0, 4'h7, 12'h000, 0, 0, 0, 16'd4};
      tbl[19] = '{1, 0, 16'h0000, 16'h0000, 0, 3'b000, 0, 4'h7, 12'h000, 0, 0, 0, 16'd4};
      tbl[20] = '{0, 0, 16'h0000, 16'h0000, 0, 3'b001, 0, 4'h7, 12'h000, 0, 0, 0, 16'd4};
      tbl[21] = '{0, 1, 16'h3001, 16'h8001, 1, 3'b001, 1, 4'h7, 12'h000, 0, 0, 0, 16'd4};
      tbl[22] = '{0, 0, 16'h0000, 16'h8001, 0, 3'b010, 0, 4'h3, 12'h001, 0, 0, 0, 16'd4};
      tbl[23] = '{0, 0, 16'h0000, 16'h8001, 0, 3'b100, 0, 4'h3, 12'h001, 1, 1, 0, 16'd4};

      // Asynchronous reset from time zero
      rst_n = 1'b0;
      run = 1'b0; acc = '0; acc_load = 1'b0;
      mem_if.mem_rdata = '0; mem_if.mem_ready = 1'b0;
      #2;
      chk_all("reset", 3'b000, 0, 4'h0, 12'h000, 0, 0, 0, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: drive at negedge, check pre-edge outputs, then the next posedge advances
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         run              = tbl[i].run;
         mem_if.mem_ready = tbl[i].rdy;
         mem_if.mem_rdata = tbl[i].rdata;
         acc              = tbl[i].acc;
         acc_load         = tbl[i].ld;
         #1;
         chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].skip, tbl[i].inst, tbl[i].op,
                 tbl[i].eq, tbl[i].mi, tbl[i].halt, tbl[i].ret);
      end

      // Reset in the middle of EXEC2 (SUB) clears everything at once
      rst_n = 1'b0;
      #1;
      chk_all("abort", 3'b000, 0, 4'h0, 12'h000, 0, 0, 0, 16'd0);

      // Restart and run one JMP: the aborted SUB must not have been counted
      @(negedge clk);
      rst_n = 1'b1; run = 1'b1; acc = '0; acc_load = 1'b0;
      mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 16'h4000;
      #1;
      chk_all("rst_idle", 3'b000, 0, 4'h0, 12'h000, 0, 0, 0, 16'd0);
      @(negedge clk); #1;
      chk_all("rst_fetch", 3'b001, 1, 4'h0, 12'h000, 0, 0, 0, 16'd0);
      @(negedge clk);
      mem_if.mem_ready = 1'b0;
      #1;
      chk_all("rst_exec1", 3'b010, 0, 4'h4, 12'h000, 0, 0, 0, 16'd0);
      @(negedge clk); #1;
      chk_all("rst_done", 3'b001, 0, 4'h4, 12'h000, 0, 0, 0, 16'd1);

      // Counter wrap: preload 0xFFFF while stalled in FETCH, then retire one JMP
      force dut.retired_q = 16'hFFFF;
      #1;
      release dut.retired_q;
      #1;
      chk("wrap_preload", 32'(retired), 32'h0000FFFF);
      @(negedge clk);
      mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 16'h4abc;
      #1;
      chk_all("wrap_fetch", 3'b001, 1, 4'h4, 12'h000, 0, 0, 0, 16'hFFFF);
      @(negedge clk);
      mem_if.mem_ready = 1'b0;
      #1;
      chk_all("wrap_exec1", 3'b010, 0, 4'h4, 12'habc, 0, 0, 0, 16'hFFFF);
      @(negedge clk); #1;
      chk_all("wrap_done", 3'b001, 0, 4'h4, 12'habc, 0, 0, 0, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
